arb_bus_mux: RTL

ARB_BUS_MUX -- requirements
Module: arb_bus_mux

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_onehot_to_idx.sv | 31 +++
 rtl/arb_bus_mux.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and default widths for the arb_bus_mux slice.
//   arb_state_e      - command FSM states
//   DEF_ADDR_W       - default address width
//   DEF_DATA_W       - default data width
//   DEF_TIMEOUT_CYC  - default response timeout in cycles (1..255)
//   CNT_W            - width of the response timeout counter
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/arb_onehot_to_idx.sv
// arb_onehot_to_idx: reduce a (nominally one-hot) grant vector to the index
// of its lowest set bit and flag when more than one bit is set.
//   grant_i  in  N      grant vector
//   idx_o    out IDX_W  index of lowest set bit (0 when grant_i is zero)
//   any_o    out 1      grant_i has at least one bit set
//   multi_o  out 1      grant_i has more than one bit set
module arb_onehot_to_idx #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     grant_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scan from the top so the last (lowest) set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (grant_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o   = |grant_i;
  // Clearing the lowest set bit leaves something only if another bit was set.
  assign multi_o = |(grant_i & (grant_i - ONE));

endmodule

// File: rtl/arb_bus_mux.sv
// arb_bus_mux: single-outstanding command mux between NUM_REQ requesters and
// one downstream memory port. The upstream arbiter supplies a one-hot grant;
// this block captures the granted request, issues it downstream, waits for the
// response (or a timeout) and routes it back to the owner.
//   clk_i, rst_i            clock, async active-high reset
//   grant_i                 one-hot grant (sampled in IDLE only)
//   req_addr_i/wdata_i/we_i flattened per-requester request fields
//   req_ack_o               1-cycle pulse: request captured
//   rsp_valid_o             1-cycle pulse: response for requester i
//   rsp_rdata_o, rsp_err_o  shared response data / timeout flag
//   mem_valid_o, mem_ready_i, mem_addr_o, mem_wdata_o, mem_we_o  command port
//   mem_rsp_valid_i, mem_rdata_i  downstream response
//   busy_o                  FSM not IDLE
//   onehot_err_o            sticky: multi-hot grant seen in IDLE
module arb_bus_mux
  import arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        grant_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic                      mem_we_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      busy_o,
  output logic                      onehot_err_o
);

  localparam int               IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [NUM_REQ-1:0] ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_we;
  logic               r_mem_valid;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;
  logic               r_onehot_err;

  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_multi;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_we;
  logic [CNT_W-1:0]   w_cnt_nxt;

  arb_onehot_to_idx #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_idx (
    .grant_i (grant_i),
    .idx_o   (w_idx),
    .any_o   (w_any),
    .multi_o (w_multi)
  );

  assign w_addr    = req_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_wdata   = req_wdata_i[int'(w_idx)*DATA_W +: DATA_W];
  assign w_we      = req_we_i[w_idx];
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_ack        <= '0;
      r_rsp_valid  <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_onehot_err <= 1'b0;
    end else begin
      // Ack and response are single-cycle pulses.
      r_ack       <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx       <= w_idx;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_we        <= w_we;
            r_ack       <= ONE << w_idx;
            r_mem_valid <= 1'b1;
            r_state     <= S_ISSUE;
            if (w_multi) r_onehot_err <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (mem_ready_i) begin
            r_mem_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          // A real response beats a timeout landing on the same edge.
          if (mem_rsp_valid_i) begin
            r_rdata     <= mem_rdata_i;
            r_err       <= 1'b0;
            r_rsp_valid <= ONE << r_idx;
            r_state     <= S_IDLE;
          end else if (w_cnt_nxt == TO_VAL) begin
            r_rdata     <= '0;
            r_err       <= 1'b1;
            r_rsp_valid <= ONE << r_idx;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack_o    = r_ack;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_rdata_o  = r_rdata;
  assign rsp_err_o    = r_err;
  assign mem_valid_o  = r_mem_valid;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_we_o     = r_we;
  assign busy_o       = (r_state != S_IDLE);
  assign onehot_err_o = r_onehot_err;

endmodule
